// File: rtl/pt_sequencer.sv
// Plaintext block sequencer feeding an AES core: emits num_blocks 128-bit blocks
// from an incrementing or Galois-LFSR generator, with optional single-block injection.
module pt_sequencer #(
    parameter int          CNT_W     = 16,
    parameter logic [127:0] LFSR_TAPS = 128'h87
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [127:0]     seed,
    input  logic [CNT_W-1:0] num_blocks,
    input  logic             inj_en,
    input  logic [CNT_W-1:0] inj_idx,
    input  logic [127:0]     inj_pattern,
    input  logic             pt_ready,
    output logic             pt_valid,
    output logic [127:0]     pt_data,
    output logic             pt_last,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] blk_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic               mode_reg;
    logic [CNT_W-1:0]   num_reg;
    logic               inj_en_reg;
    logic [CNT_W-1:0]   inj_idx_reg;
    logic [127:0]       inj_pat_reg;
    // gen_reg tracks g(blk_cnt) even when the presented block is the injected one
    logic [127:0]       gen_reg;

    logic [127:0]       seed_eff;
    logic [127:0]       gen_next;
    logic [CNT_W-1:0]   blk_next;
    logic               handshake;

    always_comb begin
        seed_eff  = (mode && seed == 128'd0) ? 128'd1 : seed;
        gen_next  = mode_reg ? ({gen_reg[126:0], 1'b0} ^ (gen_reg[127] ? LFSR_TAPS : 128'd0))
                             : gen_reg + 128'd1;
        blk_next  = blk_cnt + CNT_W'(1);
        handshake = pt_valid && pt_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            mode_reg    <= 1'b0;
            num_reg     <= '0;
            inj_en_reg  <= 1'b0;
            inj_idx_reg <= '0;
            inj_pat_reg <= '0;
            gen_reg     <= '0;
            pt_valid    <= 1'b0;
            pt_data     <= '0;
            pt_last     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            blk_cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mode_reg    <= mode;
                        num_reg     <= num_blocks;
                        inj_en_reg  <= inj_en;
                        inj_idx_reg <= inj_idx;
                        inj_pat_reg <= inj_pattern;
                        gen_reg     <= seed_eff;
                        blk_cnt     <= '0;
                        busy        <= 1'b1;
                        if (num_blocks != '0) begin
                            state    <= SEND;
                            pt_valid <= 1'b1;
                            pt_data  <= (inj_en && inj_idx == '0) ? inj_pattern : seed_eff;
                            pt_last  <= (num_blocks == CNT_W'(1));
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                SEND: begin
                    if (handshake) begin
                        blk_cnt <= blk_next;
                        if (pt_last) begin
                            state    <= DONE;
                            pt_valid <= 1'b0;
                            pt_last  <= 1'b0;
                            done     <= 1'b1;
                        end else begin
                            gen_reg <= gen_next;
                            pt_data <= (inj_en_reg && inj_idx_reg == blk_next) ? inj_pat_reg : gen_next;
                            pt_last <= (blk_next == num_reg - CNT_W'(1));
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    pt_valid <= 1'b0;
                    pt_last  <= 1'b0;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pt_sequencer.sv
// Bench for pt_sequencer: a queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed block values and latencies.
module tb_pt_sequencer;

    localparam logic [127:0] TAPS = 128'h87;
    localparam logic [127:0] PAT  = 128'h00112233_44556677_8899aabb_ccddeeff;
    localparam logic [127:0] MSB  = {1'b1, 127'd0};

    logic         clk = 1'b0;
    logic         rst, start, mode, inj_en, pt_ready;
    logic [127:0] seed, inj_pattern;
    logic [15:0]  num_blocks, inj_idx;
    logic         pt_valid, pt_last, busy, done;
    logic [127:0] pt_data;
    logic [15:0]  blk_cnt;

    pt_sequencer #(.CNT_W(16), .LFSR_TAPS(TAPS)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .seed(seed),
        .num_blocks(num_blocks), .inj_en(inj_en), .inj_idx(inj_idx),
        .inj_pattern(inj_pattern), .pt_ready(pt_ready), .pt_valid(pt_valid),
        .pt_data(pt_data), .pt_last(pt_last), .busy(busy), .done(done), .blk_cnt(blk_cnt)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int start_cyc = 0;

    // observation log of the current scenario (cycle numbers relative to start edge)
    logic [127:0] hs_data[$];
    int           hs_rel[$];
    bit           hs_last[$];
    int           done_rel, done_n;
    logic [127:0] exq[$];

    // reference model state
    bit           m_on = 0, m_send = 0, m_done = 0, m_zero = 0;
    int           m_idx = 0;
    logic [127:0] m_blocks[$];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [127:0] g_step(input logic [127:0] g, input logic m);
        if (m) return {g[126:0], 1'b0} ^ (g[127] ? TAPS : 128'd0);
        return g + 128'd1;
    endfunction

    task automatic build_blocks();
        logic [127:0] g;
        g = (mode && seed == 128'd0) ? 128'd1 : seed;
        m_blocks.delete();
        for (int i = 0; i < int'(num_blocks); i++) begin
            m_blocks.push_back((inj_en && int'(inj_idx) == i) ? inj_pattern : g);
            g = g_step(g, mode);
        end
    endtask

    // model update on each edge, comparison and logging on the falling edge
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (rst) begin
                m_on = 1; m_send = 0; m_done = 0; m_idx = 0; m_zero = 1;
            end else if (m_on) begin
                if (m_done) begin
                    m_done = 0;
                end else if (m_send) begin
                    if (pt_ready) begin
                        m_idx++;
                        if (m_idx == m_blocks.size()) begin
                            m_send = 0;
                            m_done = 1;
                        end
                    end
                end else if (start) begin
                    build_blocks();
                    m_zero = 0;
                    m_idx  = 0;
                    if (m_blocks.size() == 0) m_done = 1;
                    else                      m_send = 1;
                end
            end
            @(negedge clk);
            if (m_on) begin
                chk("pt_valid", 128'(pt_valid), 128'(m_send));
                chk("busy", 128'(busy), 128'(m_send | m_done));
                chk("done", 128'(done), 128'(m_done));
                if (m_send) begin
                    chk("pt_data", pt_data, m_blocks[m_idx]);
                    chk("pt_last", 128'(pt_last), 128'(m_idx == m_blocks.size() - 1));
                    chk("blk_cnt", 128'(blk_cnt), 128'(m_idx));
                end
                if (m_zero) begin
                    chk("rst pt_data", pt_data, 128'd0);
                    chk("rst blk_cnt", 128'(blk_cnt), 128'd0);
                    chk("rst pt_last", 128'(pt_last), 128'd0);
                end
            end
            if (!rst && pt_valid && pt_ready) begin
                hs_data.push_back(pt_data);
                hs_rel.push_back(cyc - start_cyc + 1);
                hs_last.push_back(pt_last);
                $display("[rel %0d] block %0d data=%h last=%0b", cyc - start_cyc + 1, blk_cnt, pt_data, pt_last);
            end
            if (!rst && done) begin
                done_rel = cyc - start_cyc + 1;
                done_n++;
                $display("[rel %0d] done", done_rel);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // start pulse sampled at edge t == start_cyc; afterwards inputs are scrambled
    task automatic kick(input logic m, input logic [127:0] s, input int n,
                        input logic ie, input int ii, input logic [127:0] pat);
        @(posedge clk);
        #1;
        hs_data.delete(); hs_rel.delete(); hs_last.delete();
        done_rel = -1; done_n = 0;
        mode = m; seed = s; num_blocks = 16'(n);
        inj_en = ie; inj_idx = 16'(ii); inj_pattern = pat;
        start = 1'b1;
        start_cyc = cyc + 1;
        @(posedge clk);
        #1;
        start = 1'b0;
        mode = ~m; seed = ~s; num_blocks = 16'd7; inj_en = ~ie; inj_idx = 16'd0; inj_pattern = ~pat;
    endtask

    task automatic ex(input logic [127:0] v);
        exq.push_back(v);
    endtask

    task automatic check_seq(input string nm);
        chk({nm, " count"}, 128'(hs_data.size()), 128'(exq.size()));
        for (int i = 0; i < exq.size() && i < hs_data.size(); i++)
            chk({nm, " data"}, hs_data[i], exq[i]);
        exq.delete();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; mode = 1'b0; seed = '0; num_blocks = '0;
        inj_en = 1'b0; inj_idx = '0; inj_pattern = '0; pt_ready = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(2);

        // incrementing sequence with latency pinned
        kick(1'b0, 128'h10, 3, 1'b0, 0, PAT);
        tick(5);
        ex(128'h10); ex(128'h11); ex(128'h12);
        check_seq("inc");
        if (hs_rel.size() == 3) begin
            chk("inc first rel", 128'(hs_rel[0]), 128'd1);
            chk("inc third rel", 128'(hs_rel[2]), 128'd3);
            chk("inc last flag", 128'(hs_last[2]), 128'd1);
            chk("inc non-last flag", 128'(hs_last[1]), 128'd0);
        end
        chk("inc done rel", 128'(done_rel), 128'd4);
        chk("inc done count", 128'(done_n), 128'd1);

        // LFSR from zero seed, then across the feedback tap
        kick(1'b1, 128'd0, 2, 1'b0, 0, PAT);
        tick(4);
        ex(128'h1); ex(128'h2);
        check_seq("lfsr zero");
        kick(1'b1, MSB, 2, 1'b0, 0, PAT);
        tick(4);
        ex(MSB); ex(128'h87);
        check_seq("lfsr tap");

        // injection in the middle, at index 0, and out of range
        kick(1'b0, 128'd0, 3, 1'b1, 1, PAT);
        tick(5);
        ex(128'd0); ex(PAT); ex(128'd2);
        check_seq("inj mid");
        kick(1'b1, 128'd3, 3, 1'b1, 0, PAT);
        tick(5);
        ex(PAT); ex(128'd6); ex(128'd12);
        check_seq("inj first");
        kick(1'b0, 128'd5, 3, 1'b1, 3, PAT);
        tick(5);
        ex(128'd5); ex(128'd6); ex(128'd7);
        check_seq("inj range");

        // five-cycle stall while block 1 is presented
        kick(1'b0, 128'd100, 4, 1'b0, 0, PAT);
        tick(1);
        pt_ready = 1'b0;
        tick(5);
        pt_ready = 1'b1;
        tick(5);
        ex(128'd100); ex(128'd101); ex(128'd102); ex(128'd103);
        check_seq("stall");
        if (hs_rel.size() == 4) chk("stall block1 rel", 128'(hs_rel[1]), 128'd7);
        chk("stall done rel", 128'(done_rel), 128'd10);

        // empty sequence
        kick(1'b0, 128'd9, 0, 1'b0, 0, PAT);
        tick(3);
        check_seq("empty");
        chk("empty done rel", 128'(done_rel), 128'd1);
        chk("empty done count", 128'(done_n), 128'd1);

        // start while busy is ignored
        pt_ready = 1'b0;
        kick(1'b0, 128'd200, 3, 1'b0, 0, PAT);
        mode = 1'b1; seed = 128'd500; num_blocks = 16'd2; start = 1'b1;
        tick(1);
        start = 1'b0;
        pt_ready = 1'b1;
        tick(6);
        ex(128'd200); ex(128'd201); ex(128'd202);
        check_seq("busy start");
        chk("busy start done count", 128'(done_n), 128'd1);

        // reset while block 2 of 4 is presented, then replay
        kick(1'b0, 128'd50, 4, 1'b0, 0, PAT);
        tick(2);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(4);
        ex(128'd50); ex(128'd51);
        check_seq("abort");
        chk("abort done count", 128'(done_n), 128'd0);
        kick(1'b0, 128'd50, 4, 1'b0, 0, PAT);
        tick(6);
        ex(128'd50); ex(128'd51); ex(128'd52); ex(128'd53);
        check_seq("replay");
        chk("replay done count", 128'(done_n), 128'd1);

        // irregular back-pressure on an LFSR run with injection; model checks every cycle
        kick(1'b1, MSB, 6, 1'b1, 2, PAT);
        for (int i = 0; i < 30; i++) begin
            pt_ready = ($urandom_range(0, 2) != 0);
            tick(1);
        end
        pt_ready = 1'b1;
        tick(10);
        chk("random done count", 128'(done_n), 128'd1);
        chk("random block count", 128'(hs_data.size()), 128'd6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pt_sequencer.md
PT_SEQUENCER -- requirements
Module: pt_sequencer

Interface
REQ-001 Parameter CNT_W, default 16, width of block counters and indices.
REQ-002 Parameter LFSR_TAPS, default 128'h87, Galois feedback mask for x^128+x^7+x^2+x+1.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  single-cycle request to begin a sequence; sampled only in IDLE.
REQ-006 mode  input  1  0 = incrementing sequence, 1 = LFSR sequence; captured at start.
REQ-007 seed  input  128  first block value; captured at start.
REQ-008 num_blocks  input  CNT_W  blocks to emit; captured at start.
REQ-009 inj_en  input  1  enable replacement of one block by inj_pattern; captured at start.
REQ-010 inj_idx  input  CNT_W  zero-based index of the block to replace; captured at start.
REQ-011 inj_pattern  input  128  replacement block value (e.g. 128'h00112233_44556677_8899aabb_ccddeeff); captured at start.
REQ-012 pt_ready  input  1  downstream AES core accepts pt_data.
REQ-013 pt_valid  output  1  pt_data holds a valid block.
REQ-014 pt_data  output  128  plaintext block toward AES state input.
REQ-015 pt_last  output  1  high with pt_valid on the final block.
REQ-016 busy  output  1  high in SEND and DONE.
REQ-017 done  output  1  one-cycle pulse after final handshake.
REQ-018 blk_cnt  output  CNT_W  index of the block currently presented (number of completed handshakes).

Function
REQ-019 FSM states IDLE, SEND, DONE; IDLE->SEND on start with num_blocks!=0; IDLE->DONE on start with num_blocks==0; SEND->DONE on handshake of last block; DONE->IDLE unconditionally after one cycle.
REQ-020 Handshake = pt_valid && pt_ready in the same cycle; only a handshake advances the sequence.
REQ-021 Start sampled at edge t -> pt_valid high from cycle t+1 with block 0; no bubble between consecutive blocks while pt_ready stays high (one block per cycle).
REQ-022 While pt_valid && !pt_ready, pt_data, pt_last and blk_cnt hold stable; pt_valid never drops before handshake.
REQ-023 Generator value g(0)=seed; mode 0: g(i+1)=g(i)+1 modulo 2^128; mode 1: g(i+1)= (g(i)<<1) XOR (g(i)[127] ? LFSR_TAPS : 0).
REQ-024 Mode 1 with seed==0 uses g(0)=128'h1 instead.
REQ-025 pt_data = inj_pattern when inj_en && blk_cnt==inj_idx, else g(blk_cnt); injection does not disturb the generator sequence (g advances past the replaced index).
REQ-026 inj_idx >= num_blocks: no replacement occurs.
REQ-027 pt_last = pt_valid && (blk_cnt == num_blocks-1).
REQ-028 done high exactly in DONE state; busy high in SEND and DONE; pt_valid low outside SEND.
REQ-029 start while busy is ignored; inputs other than pt_ready are don't-care outside the start cycle.
REQ-030 num_blocks==0: no pt_valid, done pulses in cycle t+1.

Reset
REQ-031 rst at an edge forces IDLE; pt_valid=0, pt_last=0, busy=0, done=0, blk_cnt=0, pt_data=0 from the next cycle.
REQ-032 rst mid-sequence aborts without done pulse; rst overrides a simultaneous start.

Verification
REQ-033 mode 0, seed=128'h10, num_blocks=3, pt_ready=1 -> pt_data 10,11,12 on cycles t+1..t+3, pt_last on 12, done at t+4.
REQ-034 mode 1, seed=0, num_blocks=2 -> pt_data 128'h1 then 128'h2; seed=128'h8000...0 -> next block 128'h87.
REQ-035 mode 0, seed=0, inj_en=1, inj_idx=1, inj_pattern=128'h00112233_44556677_8899aabb_ccddeeff, num_blocks=3 -> 0, injected pattern, 2.
REQ-036 pt_ready low 5 cycles during block 1 -> pt_valid held, pt_data/blk_cnt stable, sequence resumes unchanged.
REQ-037 num_blocks=0 -> no pt_valid, done pulse at t+1; start during SEND ignored.
REQ-038 rst asserted on block 2 of 4 -> all outputs 0 next cycle, no done; fresh start replays from seed.
